// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the HI/LO multiply/divide unit: owns HI/LO and a registered Busy window.
// Build option: define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate support.
module muldiv_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b1000;
    localparam logic [3:0] OP_MADDU = 4'b1001;
    localparam logic [3:0] OP_MSUB  = 4'b1010;
    localparam logic [3:0] OP_MSUBU = 4'b1011;
`endif

    localparam logic [3:0] MulInit = 4'(MULT_LAT - 1);
    localparam logic [3:0] DivInit = 4'(DIV_LAT - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      stateReg, stateNext;
    logic [3:0]  countReg, countNext;
    logic [63:0] pendingReg, pendingNext;
    logic        commitOkReg, commitOkNext;
    logic        busyReg, busyNext;
    logic [31:0] hiReg, hiNext;
    logic [31:0] loReg, loNext;

    // Full-width products
    logic [63:0] prodS, prodU;
    assign prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prodU = {32'd0, A} * {32'd0, B};

    // Signed division on magnitudes so INT_MIN / -1 wraps to INT_MIN with remainder 0.
    // A zero divisor is replaced by 1 to keep the datapath defined; the commit is suppressed anyway.
    logic [31:0] aMag, bMag, divS, divU;
    logic [31:0] qMag, rMag, qS, rS, qU, rU;
    assign aMag = A[31] ? (~A + 32'd1) : A;
    assign bMag = B[31] ? (~B + 32'd1) : B;
    assign divS = (bMag == 32'd0) ? 32'd1 : bMag;
    assign divU = (B == 32'd0) ? 32'd1 : B;
    assign qMag = aMag / divS;
    assign rMag = aMag % divS;
    assign qS   = (A[31] ^ B[31]) ? (~qMag + 32'd1) : qMag;
    assign rS   = A[31] ? (~rMag + 32'd1) : rMag;
    assign qU   = A / divU;
    assign rU   = A % divU;

`ifdef MULDIV_MADD_EN
    logic [63:0] accIn;
    assign accIn = {hiReg, loReg};
`endif

    always_comb begin
        stateNext    = stateReg;
        countNext    = countReg;
        pendingNext  = pendingReg;
        commitOkNext = commitOkReg;
        hiNext       = hiReg;
        loNext       = loReg;
        case (stateReg)
            IDLE: begin
                if (Start && !Flush) begin
                    case (Op)
                        OP_MULT: begin
                            pendingNext = prodS;  commitOkNext = 1'b1;
                            stateNext = MUL;      countNext = MulInit;
                        end
                        OP_MULTU: begin
                            pendingNext = prodU;  commitOkNext = 1'b1;
                            stateNext = MUL;      countNext = MulInit;
                        end
                        OP_DIV: begin
                            pendingNext = {rS, qS};  commitOkNext = (B != 32'd0);
                            stateNext = DIV;         countNext = DivInit;
                        end
                        OP_DIVU: begin
                            pendingNext = {rU, qU};  commitOkNext = (B != 32'd0);
                            stateNext = DIV;         countNext = DivInit;
                        end
                        OP_MTHI: hiNext = A;
                        OP_MTLO: loNext = A;
`ifdef MULDIV_MADD_EN
                        OP_MADD: begin
                            pendingNext = accIn + prodS;  commitOkNext = 1'b1;
                            stateNext = MUL;              countNext = MulInit;
                        end
                        OP_MADDU: begin
                            pendingNext = accIn + prodU;  commitOkNext = 1'b1;
                            stateNext = MUL;              countNext = MulInit;
                        end
                        OP_MSUB: begin
                            pendingNext = accIn - prodS;  commitOkNext = 1'b1;
                            stateNext = MUL;              countNext = MulInit;
                        end
                        OP_MSUBU: begin
                            pendingNext = accIn - prodU;  commitOkNext = 1'b1;
                            stateNext = MUL;              countNext = MulInit;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                // Flush wins over a commit due in the same cycle
                if (Flush) begin
                    stateNext = IDLE;
                    countNext = 4'd0;
                end else if (countReg == 4'd0) begin
                    stateNext = IDLE;
                    if (commitOkReg) begin
                        hiNext = pendingReg[63:32];
                        loNext = pendingReg[31:0];
                    end
                end else begin
                    countNext = countReg - 4'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = 4'd0;
            end
        endcase
        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg    <= IDLE;
            countReg    <= 4'd0;
            pendingReg  <= 64'd0;
            commitOkReg <= 1'b0;
            busyReg     <= 1'b0;
            hiReg       <= 32'd0;
            loReg       <= 32'd0;
        end else begin
            stateReg    <= stateNext;
            countReg    <= countNext;
            pendingReg  <= pendingNext;
            commitOkReg <= commitOkNext;
            busyReg     <= busyNext;
            hiReg       <= hiNext;
            loReg       <= loNext;
        end
    end

    assign Busy = busyReg;
    assign HI   = hiReg;
    assign LO   = loReg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, corner sequences, randomized ops vs. model.
// Expectations follow MULDIV_MADD_EN the same way the design does.
module tb_muldiv_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] A, B;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI, LO;

    int nChecks = 0;
    int nFail   = 0;

    muldiv_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          flushAt;
        int          expBusy;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current (idle) cycle, then count consecutive Busy cycles.
    // flushAt = n raises Flush during the n-th busy cycle (0 = never).
    task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flushAt, output int busyCycles);
        Start = 1'b1; Op = op; A = a; B = b;
        tick();
        Start = 1'b0; Op = 4'd0;
        busyCycles = 0;
        while (Busy && busyCycles < 64) begin
            busyCycles++;
            if (busyCycles == flushAt) Flush = 1'b1;
            tick();
            Flush = 1'b0;
        end
    endtask

    // Architectural model: what HI/LO become and how long the unit is busy.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        acc = {hi, lo};
        lat = 0;
        case (op)
            4'd1: begin p = 64'(sa * sb); {hi, lo} = p; lat = MULT_LAT; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; lat = MULT_LAT; end
            4'd3: begin
                lat = DIV_LAT;
                if (b != 0) begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            4'd4: begin
                lat = DIV_LAT;
                if (b != 0) begin lo = a / b; hi = a % b; end
            end
            4'd5: hi = a;
            4'd6: lo = a;
`ifdef MULDIV_MADD_EN
            4'd8:  begin p = acc + 64'(sa * sb); {hi, lo} = p; lat = MULT_LAT; end
            4'd9:  begin p = acc + {32'd0, a} * {32'd0, b}; {hi, lo} = p; lat = MULT_LAT; end
            4'd10: begin p = acc - 64'(sa * sb); {hi, lo} = p; lat = MULT_LAT; end
            4'd11: begin p = acc - {32'd0, a} * {32'd0, b}; {hi, lo} = p; lat = MULT_LAT; end
`endif
            default: ;
        endcase
    endtask

    initial begin
        int          bc;
        logic [31:0] hiM, loM, hiT, loT;
        int          lat, expBusy, flushAt;
        logic [3:0]  op;
        logic [31:0] a, b;

        reset_n = 1'b0; Start = 1'b0; Op = 4'd0; A = 32'd0; B = 32'd0; Flush = 1'b0;
        repeat (2) tick();
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_hi", {32'd0, HI}, 64'd0);
        check("reset_lo", {32'd0, LO}, 64'd0);
        reset_n = 1'b1;
        tick();

        vecs[0]  = '{4'd1, 32'hFFFFFFFF, 32'd2, 0, 5, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'd2, 0, 5, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2, 0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{4'd4, 32'd7, 32'd0, 0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{4'd5, 32'h12345678, 32'd0, 0, 0, 32'h12345678, 32'hFFFFFFFD};
        vecs[5]  = '{4'd3, 32'd100, 32'd3, 3, 3, 32'h12345678, 32'hFFFFFFFD};
        vecs[6]  = '{4'd1, 32'd3, 32'd5, 0, 5, 32'd0, 32'd15};
        vecs[7]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 0, 10, 32'd0, 32'h80000000};
        vecs[8]  = '{4'd7, 32'h55555555, 32'd9, 0, 0, 32'd0, 32'h80000000};
        vecs[9]  = '{4'd6, 32'hFFFFFFFF, 32'd0, 0, 0, 32'd0, 32'hFFFFFFFF};
        vecs[10] = '{4'd4, 32'd100, 32'd7, 0, 10, 32'd2, 32'd14};
`ifdef MULDIV_MADD_EN
        vecs[11] = '{4'd9, 32'd1, 32'd1, 0, 5, 32'd1, 32'd0};
`else
        vecs[11] = '{4'd9, 32'd1, 32'd1, 0, 0, 32'd2, 32'd14};
`endif
        // Vector 11 follows a DIVU that leaves HI=2/LO=14; reload HI=0/LO=FFFFFFFF before it.

        for (int i = 0; i < 12; i++) begin
            if (i == 11) begin
                runOp(4'd5, 32'd0, 32'd0, 0, bc);
                runOp(4'd6, 32'hFFFFFFFF, 32'd0, 0, bc);
`ifndef MULDIV_MADD_EN
                vecs[11].expHi = 32'd0;
                vecs[11].expLo = 32'hFFFFFFFF;
`endif
            end
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].flushAt, bc);
            $display("vec %0d op=%h a=%h b=%h flush=%0d busy=%0d hi=%h lo=%h",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].flushAt, bc, HI, LO);
            check($sformatf("vec%0d_busy", i), 64'(bc), 64'(vecs[i].expBusy));
            check($sformatf("vec%0d_hi", i), {32'd0, HI}, {32'd0, vecs[i].expHi});
            check($sformatf("vec%0d_lo", i), {32'd0, LO}, {32'd0, vecs[i].expLo});
        end

        // MTLO issued while busy must be ignored
        Start = 1'b1; Op = 4'd1; A = 32'd3; B = 32'd5;
        tick();
        Start = 1'b1; Op = 4'd6; A = 32'hDEADBEEF;
        tick();
        Start = 1'b0; Op = 4'd0;
        check("mtlo_busy_lo", {32'd0, LO}, {32'd0, vecs[11].expLo});
        bc = 2;
        while (Busy && bc < 64) begin bc++; tick(); end
        $display("seq mtlo_while_busy busy=%0d hi=%h lo=%h", bc - 1, HI, LO);
        check("mtlo_busy_cycles", 64'(bc - 1), 64'(MULT_LAT));
        check("mtlo_busy_hi", {32'd0, HI}, 64'd0);
        check("mtlo_busy_lo_end", {32'd0, LO}, 64'd15);

        // Flush in IDLE blocks a simultaneous Start
        Flush = 1'b1; Start = 1'b1; Op = 4'd5; A = 32'hAAAA5555;
        tick();
        check("idle_flush_mthi", {32'd0, HI}, 64'd0);
        Op = 4'd1;
        tick();
        Flush = 1'b0; Start = 1'b0; Op = 4'd0;
        $display("seq idle_flush busy=%0d hi=%h lo=%h", Busy, HI, LO);
        check("idle_flush_mult_busy", {63'd0, Busy}, 64'd0);

        // Asynchronous reset in the second busy cycle
        Start = 1'b1; Op = 4'd1; A = 32'd3; B = 32'd5;
        tick();
        Start = 1'b0; Op = 4'd0;
        tick();
        reset_n = 1'b0;
        #1;
        $display("seq reset_midop busy=%0d hi=%h lo=%h", Busy, HI, LO);
        check("rst_mid_busy", {63'd0, Busy}, 64'd0);
        check("rst_mid_lo", {32'd0, LO}, 64'd0);
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        check("rst_mid_late_hi", {32'd0, HI}, 64'd0);
        check("rst_mid_late_lo", {32'd0, LO}, 64'd0);
        check("rst_mid_late_busy", {63'd0, Busy}, 64'd0);

        // Randomized ops against the model
        hiM = 32'd0; loM = 32'd0;
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            flushAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 11)) : 0;
            hiT = hiM; loT = loM;
            model(op, a, b, hiT, loT, lat);
            if (flushAt != 0 && flushAt <= lat) begin
                expBusy = flushAt;
            end else begin
                expBusy = lat;
                hiM = hiT; loM = loT;
            end
            runOp(op, a, b, flushAt, bc);
            $display("rnd %0d op=%h a=%h b=%h flush=%0d busy=%0d hi=%h lo=%h",
                     i, op, a, b, flushAt, bc, HI, LO);
            check("rnd_busy", 64'(bc), 64'(expBusy));
            check("rnd_hilo", {HI, LO}, {hiM, loM});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide resource in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a fixed-latency busy window.
- Drives the registered Busy consumed by the hazard unit, which stalls HI/LO-class instructions in ID. Owns the architectural HI/LO registers.
- Supports cancellation of an in-flight operation on pipeline flush.

Parameters:
- MULT_LAT, 5, Busy cycles for MULT/MULTU (and MADD-class when enabled); legal range 1..15.
- DIV_LAT, 10, Busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- Start  in  1  EX holds a HI/LO op this cycle; qualifies Op.
- Op  in  4  0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 1000 MADD, 1001 MADDU, 1010 MSUB, 1011 MSUBU; all other codes are no-op.
- A  in  32  rs operand, already forwarded.
- B  in  32  rt operand, already forwarded.
- Flush  in  1  cancel the in-flight op (exception/flush).
- Busy  out  1  registered; high while an op occupies the unit.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.

Behaviour:
- Reset (async, reset_n=0): state IDLE, counter 0, Busy=0, HI=0, LO=0, pending result 0. Takes effect immediately, including mid-operation; an in-flight result is discarded.
- FSM states: IDLE, MUL, DIV.
- Acceptance: Start accepted only in IDLE with Flush=0. Start while Busy=1 or Flush=1 is ignored; the hazard unit guarantees no such issue, but the block must not corrupt state if it happens.
- MULT/MULTU accepted:
  - Full 64-bit product of A*B (signed/unsigned) latched into the pending register at the acceptance edge.
  - Go to MUL, counter=MULT_LAT-1, Busy=1 from the next cycle.
- DIV/DIVU accepted:
  - Quotient/remainder latched into pending; go to DIV, counter=DIV_LAT-1.
  - Signed: truncate toward zero; remainder takes the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF signed: quotient 0x80000000, remainder 0.
  - B=0: operation still runs DIV_LAT busy cycles; commit is suppressed and HI/LO stay unchanged.
- MTHI/MTLO accepted: HI (resp. LO) <= A at that edge. No busy window; state stays IDLE.
- MUL/DIV states:
  - Counter decrements each cycle.
  - In the cycle counter==0 (the last busy cycle), the next edge commits pending to HI (upper/remainder) and LO (lower/quotient), clears Busy and returns to IDLE.
  - Busy is high for exactly MULT_LAT or DIV_LAT consecutive cycles, and the new HI/LO are visible in the first cycle Busy=0.
- Back-to-back issue: Start may be accepted in the very cycle Busy first reads 0.
- Flush: when Flush=1 in MUL/DIV, the next edge returns to IDLE with Busy=0 and no commit. Flush=1 in IDLE blocks a simultaneous Start, including MTHI/MTLO.
- No-op Op codes with Start=1: no state change.
- Outputs HI/LO/Busy come directly from flops; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - Op 1000/1001 (MADD/MADDU): pending = {HI,LO} + A*B (signed/unsigned), using {HI,LO} sampled at acceptance.
  - Op 1010/1011 (MSUB/MSUBU): pending = {HI,LO} - A*B.
  - All four run MULT_LAT cycles in MUL state; 64-bit arithmetic wraps modulo 2^64.
- Undefined: codes 1000-1011 are no-ops (no Busy, HI/LO unchanged). No accumulate logic is synthesised.

Test Plan:
- Reset mid-op: MULT A=3, B=5, deassert reset_n in the second busy cycle -> Busy=0, HI=0, LO=0 immediately; no later commit.
- MULT A=0xFFFFFFFF, B=2 -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=-7 (0xFFFFFFF9), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> Busy for 10 cycles, HI/LO unchanged.
- MTHI A=0x12345678 -> HI=0x12345678 next cycle, Busy stays 0. MTLO with Start issued while Busy=1 -> ignored, LO unchanged.
- Flush in the 3rd busy cycle of DIV A=100, B=3 -> Busy=0 next cycle, HI/LO keep prior values. A MULT issued the following cycle completes normally.
- With MULDIV_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> after 5 cycles HI=1, LO=0. Without the macro, the same stimulus leaves Busy=0 and HI/LO unchanged.
